// File: rtl/regfile.sv
// 32x32 general-purpose register file: one synchronous write port, two
// combinational read ports, entry 0 hardwired to zero, async active-low clear.
module regfile #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rsNum,
    input  logic [ADDR_W-1:0] rtNum,
    input  logic [ADDR_W-1:0] rdNum,
    input  logic [WIDTH-1:0]  rdData,
    input  logic              rdWriteEnable,
    output logic [WIDTH-1:0]  rsData,
    output logic [WIDTH-1:0]  rtData
);

    logic [WIDTH-1:0] w_entry [NUM_REGS];

    for (genvar gi = 0; gi < int'(NUM_REGS); gi++) begin : g_entry
        if (gi == 0) begin : g_zero
            assign w_entry[gi] = '0;
        end else begin : g_reg
            logic             w_wen;
            logic [WIDTH-1:0] r_q;

            // One-hot decode: only the addressed entry loads on the edge.
            assign w_wen = rdWriteEnable && (rdNum == ADDR_W'(gi));

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_q <= '0;
                end else if (w_wen) begin
                    r_q <= rdData;
                end
            end

            assign w_entry[gi] = r_q;
        end
    end

    // No write-to-read bypass: a pending write is visible only after its edge.
    assign rsData = w_entry[rsNum];
    assign rtData = w_entry[rtNum];

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile with hand-computed expected values.
module tb_regfile;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned ADDR_W = 5;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] rsNum;
    logic [ADDR_W-1:0] rtNum;
    logic [ADDR_W-1:0] rdNum;
    logic [WIDTH-1:0]  rdData;
    logic              rdWriteEnable;
    logic [WIDTH-1:0]  rsData;
    logic [WIDTH-1:0]  rtData;

    int n_checks = 0;
    int n_errors = 0;

    regfile #(.WIDTH(32), .NUM_REGS(32), .ADDR_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .rsNum        (rsNum),
        .rtNum        (rtNum),
        .rdNum        (rdNum),
        .rdData       (rdData),
        .rdWriteEnable(rdWriteEnable),
        .rsData       (rsData),
        .rtData       (rtData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic write_reg(input logic [ADDR_W-1:0] num, input logic [WIDTH-1:0] data);
        @(negedge clk);
        rdNum         = num;
        rdData        = data;
        rdWriteEnable = 1'b1;
        @(posedge clk);
        #1;
        rdWriteEnable = 1'b0;
    endtask

    task automatic read_ports(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        rsNum = a;
        rtNum = b;
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] exp_a;
        logic [WIDTH-1:0] exp_b;

        reset         = 1'b0;
        rsNum         = '0;
        rtNum         = '0;
        rdNum         = '0;
        rdData        = '0;
        rdWriteEnable = 1'b0;

        // Reset state
        #2;
        read_ports(5'd5, 5'd31);
        check("reset_rs", rsData, 32'h0);
        check("reset_rt", rtData, 32'h0);
        #20;
        reset = 1'b1;

        // Reset clears everything, mid-cycle pulse
        write_reg(5'd5, 32'hDEADBEEF);
        read_ports(5'd5, 5'd5);
        check("r5_written", rsData, 32'hDEADBEEF);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("r5_during_reset_rs", rsData, 32'h0);
        check("r5_during_reset_rt", rtData, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        check("r5_after_reset", rsData, 32'h0);
        @(posedge clk);
        #1;
        check("r5_after_edge", rsData, 32'h0);

        // Basic write/read on both ports
        write_reg(5'd7, 32'h12345678);
        write_reg(5'd31, 32'hCAFEF00D);
        read_ports(5'd7, 5'd31);
        check("rs_r7", rsData, 32'h12345678);
        check("rt_r31", rtData, 32'hCAFEF00D);
        read_ports(5'd7, 5'd7);
        check("same_rs", rsData, 32'h12345678);
        check("same_rt", rtData, 32'h12345678);

        // Zero register ignores writes and disturbs nothing
        write_reg(5'd1, 32'hA5A5A5A5);
        write_reg(5'd0, 32'hFFFFFFFF);
        read_ports(5'd0, 5'd1);
        check("r0_zero", rsData, 32'h0);
        check("r1_kept", rtData, 32'hA5A5A5A5);
        read_ports(5'd31, 5'd7);
        check("r31_kept", rsData, 32'hCAFEF00D);
        check("r7_kept", rtData, 32'h12345678);

        // Enable low, then write collision with no bypass
        write_reg(5'd3, 32'h11);
        @(negedge clk);
        rdNum         = 5'd3;
        rdData        = 32'h22;
        rdWriteEnable = 1'b0;
        rsNum         = 5'd3;
        @(posedge clk);
        #1;
        check("we_low_hold", rsData, 32'h11);
        @(negedge clk);
        rdWriteEnable = 1'b1;
        #1;
        check("collision_old", rsData, 32'h11);
        @(posedge clk);
        #1;
        check("collision_new", rsData, 32'h22);
        rdWriteEnable = 1'b0;

        // Reset held across a write edge beats the write
        @(negedge clk);
        reset         = 1'b0;
        rdNum         = 5'd9;
        rdData        = 32'h55;
        rdWriteEnable = 1'b1;
        @(posedge clk);
        #1;
        rdWriteEnable = 1'b0;
        read_ports(5'd9, 5'd3);
        check("r9_in_reset", rsData, 32'h0);
        check("r3_cleared", rtData, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("r9_after_release", rsData, 32'h0);
        @(posedge clk);
        #1;
        check("r9_after_edge", rsData, 32'h0);

        // Full sweep through both ports
        for (int i = 1; i < 32; i++) begin
            write_reg(ADDR_W'(i), WIDTH'(i) * 32'h01010101);
        end
        for (int i = 0; i < 32; i++) begin
            read_ports(ADDR_W'(i), ADDR_W'(31 - i));
            exp_a = WIDTH'(i) * 32'h01010101;
            exp_b = WIDTH'(31 - i) * 32'h01010101;
            check($sformatf("sweep_rs_%0d", i), rsData, exp_a);
            check($sformatf("sweep_rt_%0d", 31 - i), rtData, exp_b);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
